vga_scan_driver: RTL and testbench

- VGA timing generator and pixel output stage: the driver side of the pixelX/pixelY/piece_on interface that piece modules consume.
- Scans 640x480@60 Hz coordinates, generates hsync/vsync, and samples piece_on to form registered RGB.
- Produces clk_refresh, the once-per-frame strobe that advances piece position state.
- Sits between the board clock/pins and all piece modules.

---
 rtl/vga_timing_pkg.sv | 37 +++
 rtl/vga_pixel_tick.sv | 31 +++
 rtl/vga_scan_driver.sv | 90 +++++++++
 tb/tb_vga_scan_driver.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 VGA timing defaults, colour type and window helper
// used by the scan driver and anything that decodes its coordinates.
package vga_timing_pkg;

  localparam int unsigned COORD_W = 10;

  localparam int unsigned VGA_H_DISPLAY = 640;
  localparam int unsigned VGA_H_FP      = 16;
  localparam int unsigned VGA_H_SYNC    = 96;
  localparam int unsigned VGA_H_BP      = 48;
  localparam int unsigned VGA_V_DISPLAY = 480;
  localparam int unsigned VGA_V_FP      = 10;
  localparam int unsigned VGA_V_SYNC    = 2;
  localparam int unsigned VGA_V_BP      = 33;
  localparam int unsigned VGA_CLK_DIV   = 2;

  localparam int unsigned VGA_H_TOTAL      = VGA_H_DISPLAY + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int unsigned VGA_V_TOTAL      = VGA_V_DISPLAY + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  localparam int unsigned VGA_H_SYNC_START = VGA_H_DISPLAY + VGA_H_FP;
  localparam int unsigned VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC;
  localparam int unsigned VGA_V_SYNC_START = VGA_V_DISPLAY + VGA_V_FP;
  localparam int unsigned VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC;

  typedef logic [2:0] rgb_t;

  localparam rgb_t PIECE_RGB = 3'b111;
  localparam rgb_t BG_RGB    = 3'b001;
  localparam rgb_t BLANK_RGB = 3'b000;

  // Half-open window test done at 32 bits so an end bound of 1024 still works.
  function automatic logic in_window(input logic [COORD_W-1:0] pos,
                                     input int unsigned lo,
                                     input int unsigned hi);
    return (32'(pos) >= lo) && (32'(pos) < hi);
  endfunction

endpackage

// File: rtl/vga_pixel_tick.sv
// Pixel-tick divider: tick is high for one board clock out of every CLK_DIV.
module vga_pixel_tick #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned     DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_next;

  always_comb begin
    div_next = (div == DIV_LAST) ? '0 : div + DIV_W'(1);
  end

  // tick is kept equal to (div == DIV_LAST) but comes straight from a flop.
  always_ff @(posedge clk) begin
    if (!reset) begin
      div  <= '0;
      tick <= (DIV_LAST == '0);
    end else begin
      div  <= div_next;
      tick <= (div_next == DIV_LAST);
    end
  end

endmodule

// File: rtl/vga_scan_driver.sv
// VGA scan counters plus one-tick-delayed sync/colour output stage and the
// per-frame clk_refresh level that piece modules use to advance position.
module vga_scan_driver
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_DISPLAY   = VGA_H_DISPLAY,
  parameter int unsigned H_FP        = VGA_H_FP,
  parameter int unsigned H_SYNC      = VGA_H_SYNC,
  parameter int unsigned H_BP        = VGA_H_BP,
  parameter int unsigned V_DISPLAY   = VGA_V_DISPLAY,
  parameter int unsigned V_FP        = VGA_V_FP,
  parameter int unsigned V_SYNC      = VGA_V_SYNC,
  parameter int unsigned V_BP        = VGA_V_BP,
  parameter int unsigned CLK_DIV     = VGA_CLK_DIV,
  parameter rgb_t        PIECE_COLOR = PIECE_RGB,
  parameter rgb_t        BG_COLOR    = BG_RGB
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               piece_on,
  output logic [COORD_W-1:0] pixelX,
  output logic [COORD_W-1:0] pixelY,
  output logic               clk_refresh,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic [2:0]         rgb
);

  localparam int unsigned H_TOTAL      = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL      = V_DISPLAY + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_SYNC_START = H_DISPLAY + H_FP;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int unsigned V_SYNC_START = V_DISPLAY + V_FP;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

  logic               tick;
  logic [COORD_W-1:0] h;
  logic [COORD_W-1:0] v;
  logic               h_last;
  logic               v_last;
  logic               vis;
  logic               hs_active;
  logic               vs_active;

  vga_pixel_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_pixel_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  always_comb begin
    h_last    = (h == COORD_W'(H_TOTAL - 1));
    v_last    = (v == COORD_W'(V_TOTAL - 1));
    vis       = (32'(h) < H_DISPLAY) && (32'(v) < V_DISPLAY);
    hs_active = in_window(h, H_SYNC_START, H_SYNC_END);
    vs_active = in_window(v, V_SYNC_START, V_SYNC_END);
  end

  // Stage 0 counters and stage 1 outputs both advance only on a pixel tick.
  always_ff @(posedge clk) begin
    if (!reset) begin
      h           <= '0;
      v           <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      video_on    <= 1'b0;
      rgb         <= BLANK_RGB;
      clk_refresh <= 1'b0;
    end else if (tick) begin
      if (h_last) begin
        h <= '0;
        v <= v_last ? '0 : v + COORD_W'(1);
      end else begin
        h <= h + COORD_W'(1);
      end
      video_on    <= vis;
      rgb         <= vis ? (piece_on ? PIECE_COLOR : BG_COLOR) : BLANK_RGB;
      hsync       <= ~hs_active;
      vsync       <= ~vs_active;
      clk_refresh <= (32'(v) >= V_DISPLAY);
    end
  end

  assign pixelX = h;
  assign pixelY = v;

endmodule

// File: tb/tb_vga_scan_driver.sv
// Directed bench: full-timing builds at CLK_DIV=2 and 1, plus a shrunken-timing
// build so whole frames fit in a short run.
module tb_vga_scan_driver;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // a: 640x480, CLK_DIV=2
  logic [9:0] a_px, a_py;
  logic       a_cr, a_hs, a_vs, a_von, a_pon;
  logic [2:0] a_rgb;
  // b: 640x480, CLK_DIV=1
  logic [9:0] b_px, b_py;
  logic       b_cr, b_hs, b_vs, b_von, b_pon;
  logic [2:0] b_rgb;
  // s: 8+2+3+3 by 6+2+2+2 (16x12), CLK_DIV=1
  logic [9:0] s_px, s_py;
  logic       s_cr, s_hs, s_vs, s_von;
  logic [2:0] s_rgb;

  assign a_pon = (a_px >= 10'd310) && (a_px <= 10'd328) && (a_py <= 10'd49);
  assign b_pon = (b_px >= 10'd310) && (b_px <= 10'd328) && (b_py <= 10'd49);

  vga_scan_driver #(.CLK_DIV(2)) dut_a (
    .clk(clk), .reset(reset), .piece_on(a_pon), .pixelX(a_px), .pixelY(a_py),
    .clk_refresh(a_cr), .hsync(a_hs), .vsync(a_vs), .video_on(a_von), .rgb(a_rgb));

  vga_scan_driver #(.CLK_DIV(1)) dut_b (
    .clk(clk), .reset(reset), .piece_on(b_pon), .pixelX(b_px), .pixelY(b_py),
    .clk_refresh(b_cr), .hsync(b_hs), .vsync(b_vs), .video_on(b_von), .rgb(b_rgb));

  vga_scan_driver #(
    .H_DISPLAY(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_DISPLAY(6), .V_FP(2), .V_SYNC(2), .V_BP(2), .CLK_DIV(1)
  ) dut_s (
    .clk(clk), .reset(reset), .piece_on(1'b0), .pixelX(s_px), .pixelY(s_py),
    .clk_refresh(s_cr), .hsync(s_hs), .vsync(s_vs), .video_on(s_von), .rgb(s_rgb));

  function automatic logic [19:0] pos(input int which);
    case (which)
      0:       return {a_py, a_px};
      1:       return {b_py, b_px};
      default: return {s_py, s_px};
    endcase
  endfunction

  task automatic wait_xy(input int which, input int x, input int y, input int budget);
    logic [19:0] want;
    int n;
    want = {10'(y), 10'(x)};
    n = 0;
    @(negedge clk);
    while (pos(which) !== want && n < budget) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (pos(which) !== want) begin
      miscompares++;
      $display("FAIL wait_xy inst%0d: at (%0d,%0d) want (%0d,%0d)", which,
               pos(which) % 1024, pos(which) / 1024, x, y);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({a_hs, a_vs, a_von, a_rgb, a_cr} !== 7'b11_0_000_0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b want 1100000", {a_hs, a_vs, a_von, a_rgb, a_cr});
    end
    vectors++;
    if ({a_px, a_py, b_px, s_px} !== 40'd0) begin
      miscompares++;
      $display("FAIL reset_coords: a=(%0d,%0d) b=%0d s=%0d want 0", a_px, a_py, b_px, s_px);
    end
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (a_px !== 10'd0 || b_px !== 10'd1) begin
      miscompares++;
      $display("FAIL release_1clk: a_px=%0d want 0, b_px=%0d want 1", a_px, b_px);
    end
    @(negedge clk);
    vectors++;
    if (a_px !== 10'd1 || a_von !== 1'b1 || a_rgb !== 3'b001) begin
      miscompares++;
      $display("FAIL release_2clk: px=%0d von=%b rgb=%b want 1 1 001", a_px, a_von, a_rgb);
    end
  endtask

  task automatic test_hsync_line(input int which, input int clks_per_tick);
    int n;
    int lo;
    int t0;
    logic hs;
    wait_xy(which, 656, 0, 4000);
    hs = (which == 0) ? a_hs : b_hs;
    vectors++;
    if (hs !== 1'b1) begin
      miscompares++;
      $display("FAIL hsync_at_656 inst%0d: got %b want 1", which, hs);
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
      hs = (which == 0) ? a_hs : b_hs;
    end while (hs === 1'b1 && n < 10);
    vectors++;
    if (n != clks_per_tick || pos(which) % 1024 != 657) begin
      miscompares++;
      $display("FAIL hsync_fall inst%0d: after %0d clks at x=%0d want %0d clks x=657",
               which, n, pos(which) % 1024, clks_per_tick);
    end
    lo = 1;
    forever begin
      @(negedge clk);
      hs = (which == 0) ? a_hs : b_hs;
      if (hs !== 1'b0 || lo > 400) break;
      lo++;
    end
    vectors++;
    if (lo != 96 * clks_per_tick || pos(which) % 1024 != 753) begin
      miscompares++;
      $display("FAIL hsync_width inst%0d: low %0d clks rise x=%0d want %0d x=753",
               which, lo, pos(which) % 1024, 96 * clks_per_tick);
    end
    wait_xy(which, 0, 1, 2000);
    t0 = cyc;
    wait_xy(which, 0, 2, 2000);
    vectors++;
    if (cyc - t0 != 800 * clks_per_tick) begin
      miscompares++;
      $display("FAIL line_period inst%0d: got %0d clks want %0d", which, cyc - t0, 800 * clks_per_tick);
    end
  endtask

  task automatic test_mid_reset();
    wait_xy(0, 400, 2, 2000);
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if ({a_px, a_py} !== 20'd0 || {a_hs, a_vs, a_von, a_rgb, a_cr} !== 7'b11_0_000_0) begin
      miscompares++;
      $display("FAIL mid_reset: (%0d,%0d) outs %b want (0,0) 1100000",
               a_px, a_py, {a_hs, a_vs, a_von, a_rgb, a_cr});
    end
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (a_px !== 10'd1 || a_py !== 10'd0 || a_von !== 1'b1 || a_rgb !== 3'b001 || a_hs !== 1'b1) begin
      miscompares++;
      $display("FAIL resume: (%0d,%0d) von=%b rgb=%b hs=%b want (1,0) 1 001 1",
               a_px, a_py, a_von, a_rgb, a_hs);
    end
  endtask

  task automatic test_frames();
    logic prev_cr, prev_vs;
    int cr_run, vs_run, last_rise, rises, cr_falls, vs_falls;
    prev_cr = 1'b0; prev_vs = 1'b1;
    cr_run = 0; vs_run = 0; last_rise = 0; rises = 0; cr_falls = 0; vs_falls = 0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (s_cr && !prev_cr) begin
        rises++;
        vectors++;
        if (s_px !== 10'd1 || s_py !== 10'd6) begin
          miscompares++;
          $display("FAIL refresh_rise_pos: (%0d,%0d) want (1,6)", s_px, s_py);
        end
        if (rises > 1) begin
          vectors++;
          if (cyc - last_rise != 192) begin
            miscompares++;
            $display("FAIL frame_period: %0d want 192", cyc - last_rise);
          end
        end
        last_rise = cyc;
        cr_run = 0;
      end
      if (!s_cr && prev_cr) begin
        cr_falls++;
        vectors++;
        if (cr_run != 96 || s_px !== 10'd1 || s_py !== 10'd0) begin
          miscompares++;
          $display("FAIL refresh_fall: high %0d at (%0d,%0d) want 96 at (1,0)", cr_run, s_px, s_py);
        end
      end
      if (!s_vs && prev_vs) begin
        vs_falls++;
        vs_run = 0;
        vectors++;
        if (s_px !== 10'd1 || s_py !== 10'd8) begin
          miscompares++;
          $display("FAIL vsync_fall_pos: (%0d,%0d) want (1,8)", s_px, s_py);
        end
      end
      if (s_vs && !prev_vs) begin
        vectors++;
        if (vs_run != 32) begin
          miscompares++;
          $display("FAIL vsync_width: %0d want 32", vs_run);
        end
      end
      if (s_cr) cr_run++;
      if (!s_vs) vs_run++;
      prev_cr = s_cr;
      prev_vs = s_vs;
    end
    vectors++;
    if (rises != 2 || cr_falls != 2 || vs_falls != 2) begin
      miscompares++;
      $display("FAIL frame_counts: rises=%0d falls=%0d vs_falls=%0d want 2 2 2", rises, cr_falls, vs_falls);
    end
  endtask

  task automatic test_piece();
    int mx, my, ex, ey;
    logic vis;
    logic [2:0] exp_rgb;
    mx = 0; my = 0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 51 * 800; i++) begin
      @(negedge clk);
      ex = mx; ey = my;
      if (mx == 799) begin
        mx = 0;
        my = (my == 524) ? 0 : my + 1;
      end else begin
        mx++;
      end
      vis = (ex < 640) && (ey < 480);
      exp_rgb = !vis ? 3'b000 :
                ((ex >= 310 && ex <= 328 && ey <= 49) ? 3'b111 : 3'b001);
      vectors++;
      if (b_px !== 10'(mx) || b_py !== 10'(my)) begin
        miscompares++;
        $display("FAIL piece_coord: (%0d,%0d) want (%0d,%0d)", b_px, b_py, mx, my);
      end
      vectors++;
      if (b_rgb !== exp_rgb || b_von !== vis) begin
        miscompares++;
        $display("FAIL piece_rgb for (%0d,%0d): rgb=%b von=%b want %b %b",
                 ex, ey, b_rgb, b_von, exp_rgb, vis);
      end
    end
  endtask

  initial begin
    test_reset();
    test_hsync_line(0, 2);
    test_mid_reset();
    test_hsync_line(1, 1);
    test_frames();
    test_piece();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
